// File: rtl/pipeline_pkg.sv
// Shared opcode encodings and immediate-format classification for the decode stage.
package pipeline_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_type_e;

    function automatic imm_type_e imm_type_of(input logic [6:0] opc);
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: return IMM_I;
            OPC_STORE:                                  return IMM_S;
            OPC_BRANCH:                                 return IMM_B;
            OPC_LUI, OPC_AUIPC:                         return IMM_U;
            OPC_JAL:                                    return IMM_J;
            default:                                    return IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// Combinational immediate generator: classifies the opcode and returns the
// immediate sign-extended from instruction bit 31 to XLEN.
module decode_imm_gen
    import pipeline_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output imm_type_e       imm_type_o
);

    logic [31:0] imm32;

    always_comb begin
        imm_type_o = imm_type_of(instr_i[6:0]);
        imm32      = '0;
        case (imm_type_o)
            IMM_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U: imm32 = {instr_i[31:12], 12'b0};
            IMM_J: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        // Signed size cast widens U-type (and all others) with copies of bit 31.
        imm_o = XLEN'($signed(imm32));
    end

endmodule

// File: rtl/pipeline_decode_stage.sv
// Decode stage: register file, immediate generation and ID/EX register with
// valid/ready, stall and flush. Optional WB write-through: DECODE_WB_BYPASS_EN.
module pipeline_decode_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned RA_W     = $clog2(NUM_REGS)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [31:0]     instruction_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            flush_i,
    input  logic            reg_write_i,
    input  logic [RA_W-1:0] write_addr_reg_i,
    input  logic [XLEN-1:0] write_data_reg_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [6:0]      opcode_o,
    output logic [2:0]      funct3_o,
    output logic [6:0]      funct7_o,
    output logic [RA_W-1:0] rs1_o,
    output logic [RA_W-1:0] rs2_o,
    output logic [RA_W-1:0] rd_o,
    output logic [XLEN-1:0] read_data1_o,
    output logic [XLEN-1:0] read_data2_o,
    output logic [XLEN-1:0] offset_o,
    output logic [XLEN-1:0] pc_o,
    output logic            illegal_o
);

    logic [XLEN-1:0] rf_q [NUM_REGS];

    logic [XLEN-1:0] imm;
    imm_type_e       imm_type;
    logic            capture;
    logic [RA_W-1:0] rs1, rs2, rd;
    logic [XLEN-1:0] rdata1, rdata2;
    logic            use_rs1, use_rs2, use_rd, opc_ok, illegal;

    logic            valid_q,   valid_d;
    logic [6:0]      opcode_q,  opcode_d;
    logic [2:0]      funct3_q,  funct3_d;
    logic [6:0]      funct7_q,  funct7_d;
    logic [RA_W-1:0] rs1_q,     rs1_d;
    logic [RA_W-1:0] rs2_q,     rs2_d;
    logic [RA_W-1:0] rd_q,      rd_d;
    logic [XLEN-1:0] rdata1_q,  rdata1_d;
    logic [XLEN-1:0] rdata2_q,  rdata2_d;
    logic [XLEN-1:0] offset_q,  offset_d;
    logic [XLEN-1:0] pc_q,      pc_d;
    logic            illegal_q, illegal_d;

    function automatic logic field_oor(input logic [4:0] f);
        return 32'(f) >= 32'(NUM_REGS);
    endfunction

`ifdef DECODE_WB_BYPASS_EN
    function automatic logic wb_hit(input logic [RA_W-1:0] a);
        return reg_write_i && (write_addr_reg_i != '0) && (write_addr_reg_i == a);
    endfunction
`endif

    decode_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_i    (instruction_i),
        .imm_o      (imm),
        .imm_type_o (imm_type)
    );

    assign ready_o = !valid_q || ready_i;
    assign capture = valid_i && ready_o && !flush_i;

    assign rs1    = instruction_i[15 +: RA_W];
    assign rs2    = instruction_i[20 +: RA_W];
    assign rd     = instruction_i[7 +: RA_W];
    assign rdata1 = (rs1 == '0) ? '0 : rf_q[rs1];
    assign rdata2 = (rs2 == '0) ? '0 : rf_q[rs2];

    // Only fields the format actually uses are range-checked against NUM_REGS.
    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        opc_ok  = 1'b1;
        case (imm_type)
            IMM_I:        begin use_rs1 = 1'b1; use_rd  = 1'b1; end
            IMM_S, IMM_B: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
            IMM_U, IMM_J: begin use_rd  = 1'b1; end
            default: begin
                if (instruction_i[6:0] == OPC_OP) begin
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                    use_rd  = 1'b1;
                end else if (instruction_i[6:0] == OPC_FENCE) begin
                    use_rs1 = 1'b1;
                    use_rd  = 1'b1;
                end else begin
                    opc_ok = 1'b0;
                end
            end
        endcase
        illegal = !opc_ok
                || (use_rs1 && field_oor(instruction_i[19:15]))
                || (use_rs2 && field_oor(instruction_i[24:20]))
                || (use_rd  && field_oor(instruction_i[11:7]));
    end

    always_comb begin
        opcode_d  = opcode_q;
        funct3_d  = funct3_q;
        funct7_d  = funct7_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        rdata1_d  = rdata1_q;
        rdata2_d  = rdata2_q;
        offset_d  = offset_q;
        pc_d      = pc_q;
        illegal_d = illegal_q;

        if (capture) begin
            opcode_d  = instruction_i[6:0];
            funct3_d  = instruction_i[14:12];
            funct7_d  = instruction_i[31:25];
            rs1_d     = rs1;
            rs2_d     = rs2;
            rd_d      = rd;
            rdata1_d  = rdata1;
            rdata2_d  = rdata2;
            offset_d  = imm;
            pc_d      = pc_i;
            illegal_d = illegal;
`ifdef DECODE_WB_BYPASS_EN
            if (wb_hit(rs1)) rdata1_d = write_data_reg_i;
            if (wb_hit(rs2)) rdata2_d = write_data_reg_i;
        end else if (valid_q && !ready_i) begin
            if (wb_hit(rs1_q)) rdata1_d = write_data_reg_i;
            if (wb_hit(rs2_q)) rdata2_d = write_data_reg_i;
`endif
        end

        if (flush_i) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d = 1'b1;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
        end else if (reg_write_i && (write_addr_reg_i != '0)) begin
            rf_q[write_addr_reg_i] <= write_data_reg_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q   <= 1'b0;
            opcode_q  <= '0;
            funct3_q  <= '0;
            funct7_q  <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            rdata1_q  <= '0;
            rdata2_q  <= '0;
            offset_q  <= '0;
            pc_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            opcode_q  <= opcode_d;
            funct3_q  <= funct3_d;
            funct7_q  <= funct7_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            rdata1_q  <= rdata1_d;
            rdata2_q  <= rdata2_d;
            offset_q  <= offset_d;
            pc_q      <= pc_d;
            illegal_q <= illegal_d;
        end
    end

    assign valid_o      = valid_q;
    assign opcode_o     = opcode_q;
    assign funct3_o     = funct3_q;
    assign funct7_o     = funct7_q;
    assign rs1_o        = rs1_q;
    assign rs2_o        = rs2_q;
    assign rd_o         = rd_q;
    assign read_data1_o = rdata1_q;
    assign read_data2_o = rdata2_q;
    assign offset_o     = offset_q;
    assign pc_o         = pc_q;
    assign illegal_o    = illegal_q;

endmodule

// File: tb/tb_pipeline_decode_stage.sv
// Bench for pipeline_decode_stage: a 32-bit/32-register and a 64-bit/16-register
// instance share one stimulus stream and are checked against a reference model.
module tb_pipeline_decode_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        valid_i, flush_i, ready_i, reg_write;
    logic [31:0] instr;
    logic [63:0] pc, wdata;
    logic [4:0]  waddr;

    logic        a_ready, a_valid, a_ill;
    logic [6:0]  a_opc, a_f7;
    logic [2:0]  a_f3;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [31:0] a_d1, a_d2, a_off, a_pc;

    logic        b_ready, b_valid, b_ill;
    logic [6:0]  b_opc, b_f7;
    logic [2:0]  b_f3;
    logic [3:0]  b_rs1, b_rs2, b_rd;
    logic [63:0] b_d1, b_d2, b_off, b_pc;

    pipeline_decode_stage #(.XLEN(32), .NUM_REGS(32)) dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(a_ready),
        .instruction_i(instr), .pc_i(pc[31:0]), .flush_i(flush_i),
        .reg_write_i(reg_write), .write_addr_reg_i(waddr), .write_data_reg_i(wdata[31:0]),
        .valid_o(a_valid), .ready_i(ready_i), .opcode_o(a_opc), .funct3_o(a_f3),
        .funct7_o(a_f7), .rs1_o(a_rs1), .rs2_o(a_rs2), .rd_o(a_rd),
        .read_data1_o(a_d1), .read_data2_o(a_d2), .offset_o(a_off), .pc_o(a_pc),
        .illegal_o(a_ill)
    );

    pipeline_decode_stage #(.XLEN(64), .NUM_REGS(16)) dut64 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(b_ready),
        .instruction_i(instr), .pc_i(pc), .flush_i(flush_i),
        .reg_write_i(reg_write), .write_addr_reg_i(waddr[3:0]), .write_data_reg_i(wdata),
        .valid_o(b_valid), .ready_i(ready_i), .opcode_o(b_opc), .funct3_o(b_f3),
        .funct7_o(b_f7), .rs1_o(b_rs1), .rs2_o(b_rs2), .rd_o(b_rd),
        .read_data1_o(b_d1), .read_data2_o(b_d2), .offset_o(b_off), .pc_o(b_pc),
        .illegal_o(b_ill)
    );

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1, rs2, rd;
        logic [63:0] d1, d2, off, pc;
        logic        ill;
    } pay_t;

    logic [63:0] m_rf [2][32];
    bit          m_valid [2];
    pay_t        m_pay [2];
    int          n_cmp = 0;
    int          n_bad = 0;

    logic [6:0] opcs [11] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63,
                              7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F};

    function automatic logic [63:0] xmask(int c);
        return (c != 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic int nregs(int c);
        return (c != 0) ? 16 : 32;
    endfunction

    // Immediate value as a plain signed integer, built from bit weights.
    function automatic longint imm_of(input logic [31:0] i);
        longint b31 = i[31];
        longint f1, f2, f3, f4;
        case (i[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: begin
                f1 = i[31:20];
                return f1 - b31 * 4096;
            end
            7'h23: begin
                f1 = i[31:25]; f2 = i[11:7];
                return f1 * 32 + f2 - b31 * 4096;
            end
            7'h63: begin
                f1 = i[7]; f2 = i[30:25]; f3 = i[11:8];
                return f1 * 2048 + f2 * 32 + f3 * 2 - b31 * 4096;
            end
            7'h37, 7'h17: begin
                f1 = i[31:12];
                return f1 * 4096 - b31 * 64'sd4294967296;
            end
            7'h6F: begin
                f1 = i[19:12]; f2 = i[20]; f4 = i[30:21];
                return f1 * 4096 + f2 * 2048 + f4 * 2 - b31 * 1048576;
            end
            default: return 0;
        endcase
    endfunction

    function automatic pay_t build(int c);
        pay_t p;
        int n = nregs(c);
        int f1 = instr[19:15];
        int f2 = instr[24:20];
        int fd = instr[11:7];
        int wa = waddr % n;
        bit legal = 1'b1, u1 = 1'b0, u2 = 1'b0, ud = 1'b0;
        case (instr[6:0])
            7'h33:                      begin u1 = 1; u2 = 1; ud = 1; end
            7'h03, 7'h13, 7'h67, 7'h73,
            7'h0F:                      begin u1 = 1; ud = 1; end
            7'h23, 7'h63:               begin u1 = 1; u2 = 1; end
            7'h37, 7'h17, 7'h6F:        begin ud = 1; end
            default:                    legal = 0;
        endcase
        p.opc = instr[6:0];
        p.f3  = instr[14:12];
        p.f7  = instr[31:25];
        p.rs1 = 5'(f1 % n);
        p.rs2 = 5'(f2 % n);
        p.rd  = 5'(fd % n);
        p.d1  = (p.rs1 == 0) ? 64'd0 : m_rf[c][p.rs1];
        p.d2  = (p.rs2 == 0) ? 64'd0 : m_rf[c][p.rs2];
`ifdef DECODE_WB_BYPASS_EN
        if (reg_write && wa != 0 && wa == int'(p.rs1)) p.d1 = wdata & xmask(c);
        if (reg_write && wa != 0 && wa == int'(p.rs2)) p.d2 = wdata & xmask(c);
`endif
        p.off = 64'(imm_of(instr)) & xmask(c);
        p.pc  = pc & xmask(c);
        p.ill = !legal || (u1 && f1 >= n) || (u2 && f2 >= n) || (ud && fd >= n);
        return p;
    endfunction

    function automatic pay_t get_dut(int c);
        pay_t p;
        if (c == 0) begin
            p.opc = a_opc; p.f3 = a_f3; p.f7 = a_f7;
            p.rs1 = a_rs1; p.rs2 = a_rs2; p.rd = a_rd;
            p.d1 = 64'(a_d1); p.d2 = 64'(a_d2); p.off = 64'(a_off); p.pc = 64'(a_pc);
            p.ill = a_ill;
        end else begin
            p.opc = b_opc; p.f3 = b_f3; p.f7 = b_f7;
            p.rs1 = 5'(b_rs1); p.rs2 = 5'(b_rs2); p.rd = 5'(b_rd);
            p.d1 = b_d1; p.d2 = b_d2; p.off = b_off; p.pc = b_pc;
            p.ill = b_ill;
        end
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cmp_pay(input int c, input string tag, input pay_t e);
        pay_t d = get_dut(c);
        chk($sformatf("%s_c%0d_opc", tag, c), 64'(d.opc), 64'(e.opc));
        chk($sformatf("%s_c%0d_f3", tag, c),  64'(d.f3),  64'(e.f3));
        chk($sformatf("%s_c%0d_f7", tag, c),  64'(d.f7),  64'(e.f7));
        chk($sformatf("%s_c%0d_rs1", tag, c), 64'(d.rs1), 64'(e.rs1));
        chk($sformatf("%s_c%0d_rs2", tag, c), 64'(d.rs2), 64'(e.rs2));
        chk($sformatf("%s_c%0d_rd", tag, c),  64'(d.rd),  64'(e.rd));
        chk($sformatf("%s_c%0d_d1", tag, c),  d.d1,  e.d1);
        chk($sformatf("%s_c%0d_d2", tag, c),  d.d2,  e.d2);
        chk($sformatf("%s_c%0d_off", tag, c), d.off, e.off);
        chk($sformatf("%s_c%0d_pc", tag, c),  d.pc,  e.pc);
        chk($sformatf("%s_c%0d_ill", tag, c), 64'(d.ill), 64'(e.ill));
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [63:0] p,
                         input logic f, input logic r, input logic we,
                         input logic [4:0] wa, input logic [63:0] wd);
        valid_i = v; instr = i; pc = p; flush_i = f; ready_i = r;
        reg_write = we; waddr = wa; wdata = wd;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 64'd0, 1'b0, 1'b1, 1'b0, 5'd0, 64'd0);
    endtask

    task automatic do_reset();
        pay_t z = '{default: '0};
        rst_n = 1'b0;
        #1;
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 32; r++) m_rf[c][r] = '0;
            m_valid[c] = 1'b0;
            m_pay[c]   = z;
        end
        chk("rst_c0_valid", 64'(a_valid), 64'd0);
        chk("rst_c1_valid", 64'(b_valid), 64'd0);
        cmp_pay(0, "rst", z);
        cmp_pay(1, "rst", z);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock: check ready before the edge, step the model, check after it.
    task automatic cycle();
        pay_t np [2];
        bit   nv [2];
        bit   rdy, cap;
        int   wa;
        #1;
        for (int c = 0; c < 2; c++) begin
            rdy = !m_valid[c] || ready_i;
            chk($sformatf("c%0d_ready", c), 64'((c == 0) ? a_ready : b_ready), 64'(rdy));
            cap   = valid_i && rdy && !flush_i;
            np[c] = m_pay[c];
            if (cap) begin
                np[c] = build(c);
            end
`ifdef DECODE_WB_BYPASS_EN
            else if (m_valid[c] && !ready_i) begin
                wa = waddr % nregs(c);
                if (reg_write && wa != 0 && wa == int'(np[c].rs1)) np[c].d1 = wdata & xmask(c);
                if (reg_write && wa != 0 && wa == int'(np[c].rs2)) np[c].d2 = wdata & xmask(c);
            end
`endif
            nv[c] = flush_i ? 1'b0 : cap ? 1'b1 : ready_i ? 1'b0 : m_valid[c];
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < 2; c++) begin
            m_pay[c]   = np[c];
            m_valid[c] = nv[c];
            wa = waddr % nregs(c);
            if (reg_write && wa != 0) m_rf[c][wa] = wdata & xmask(c);
            chk($sformatf("c%0d_valid", c), 64'((c == 0) ? a_valid : b_valid), 64'(m_valid[c]));
            if (m_valid[c]) cmp_pay(c, "pay", m_pay[c]);
        end
    endtask

    initial begin
        idle();
        do_reset();

        // Load x5, capture a reader, then reset while the payload is valid.
        drive(1'b0, 32'd0, 64'd0, 1'b0, 1'b1, 1'b1, 5'd5, 64'hAAAA_5555);
        cycle();
        drive(1'b1, 32'h0002_8093, 64'h40, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        cycle();
        chk("pre_reset_valid", 64'(a_valid), 64'd1);
        do_reset();
        drive(1'b1, 32'h0002_8093, 64'h44, 1'b0, 1'b1, 1'b0, 5'd0, 64'd0);
        cycle();
        chk("x5_after_reset", 64'(a_d1), 64'd0);

        drive(1'b1, 32'hFE00_0EE3, 64'h80, 1'b0, 1'b1, 1'b0, 5'd0, 64'd0);
        cycle();
        chk("beq_off32", 64'(a_off), 64'h0000_0000_FFFF_FFFC);
        chk("beq_off64", b_off, 64'hFFFF_FFFF_FFFF_FFFC);
        drive(1'b1, 32'h8000_00EF, 64'h84, 1'b0, 1'b1, 1'b0, 5'd0, 64'd0);
        cycle();
        chk("jal_off32", 64'(a_off), 64'h0000_0000_FFF0_0000);
        drive(1'b1, 32'h1234_5037, 64'h88, 1'b0, 1'b1, 1'b0, 5'd0, 64'd0);
        cycle();
        chk("lui_off64", b_off, 64'h0000_0000_1234_5000);

        drive(1'b0, 32'd0, 64'd0, 1'b0, 1'b1, 1'b1, 5'd0, 64'hDEAD_BEEF);
        cycle();
        drive(1'b0, 32'd0, 64'd0, 1'b0, 1'b1, 1'b1, 5'd3, 64'h1234);
        cycle();
        drive(1'b1, 32'h0030_00B3, 64'h90, 1'b0, 1'b1, 1'b0, 5'd0, 64'd0);
        cycle();
        chk("x0_read", 64'(a_d1), 64'd0);
        chk("x3_read", 64'(a_d2), 64'h1234);
        drive(1'b1, 32'h0001_8093, 64'h94, 1'b0, 1'b1, 1'b1, 5'd3, 64'h55);
        cycle();
`ifdef DECODE_WB_BYPASS_EN
        chk("wb_same_cycle", 64'(a_d1), 64'h55);
`else
        chk("wb_same_cycle", 64'(a_d1), 64'h1234);
`endif

        // Stall for three cycles with a WB to the held rs1 in the middle one.
        drive(1'b1, 32'h0001_8093, 64'h100, 1'b0, 1'b1, 1'b0, 5'd0, 64'd0);
        cycle();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h0020_8133, 64'h104, 1'b0, 1'b0, 1'(k == 1), 5'd3, 64'h77);
            cycle();
            chk("stall_ready", 64'(a_ready), 64'd0);
        end
        chk("stall_pc", 64'(a_pc), 64'h100);
        chk("stall_opc", 64'(a_opc), 64'h13);
`ifdef DECODE_WB_BYPASS_EN
        chk("stall_d1", 64'(a_d1), 64'h77);
`else
        chk("stall_d1", 64'(a_d1), 64'h55);
`endif
        drive(1'b1, 32'h00C0_0113, 64'h108, 1'b0, 1'b1, 1'b0, 5'd0, 64'd0);
        cycle();
        chk("release_pc", 64'(a_pc), 64'h108);
        chk("release_valid", 64'(a_valid), 64'd1);

        drive(1'b1, 32'h0010_0093, 64'h200, 1'b1, 1'b1, 1'b0, 5'd0, 64'd0);
        cycle();
        chk("flush_incoming", 64'(a_valid), 64'd0);
        drive(1'b1, 32'h0010_0093, 64'h204, 1'b0, 1'b1, 1'b0, 5'd0, 64'd0);
        cycle();
        drive(1'b0, 32'd0, 64'd0, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0);
        cycle();
        chk("flush_held", 64'(a_valid), 64'd0);

        drive(1'b1, 32'h0000_007F, 64'h300, 1'b0, 1'b1, 1'b0, 5'd0, 64'd0);
        cycle();
        chk("ill_opc_c0", 64'(a_ill), 64'd1);
        chk("ill_opc_c1", 64'(b_ill), 64'd1);
        drive(1'b1, 32'h0000_0893, 64'h304, 1'b0, 1'b1, 1'b0, 5'd0, 64'd0);
        cycle();
        chk("ill_rd17_c1", 64'(b_ill), 64'd1);
        chk("rd17_c1_rd", 64'(b_rd), 64'd1);
        chk("rd17_c0_ill", 64'(a_ill), 64'd0);
        chk("rd17_c0_rd", 64'(a_rd), 64'd17);

        for (int k = 0; k < 400; k++) begin
            logic [31:0] ri;
            ri = $urandom;
            if ($urandom_range(0, 9) != 0) ri[6:0] = opcs[$urandom_range(0, 10)];
            drive(1'($urandom_range(0, 9) < 7), ri, {$urandom, $urandom},
                  1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 9) < 6),
                  1'($urandom_range(0, 1)), 5'($urandom), {$urandom, $urandom});
            cycle();
        end

        idle();
        cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_decode_stage.md
Name: pipeline_decode_stage

Overview:
- Parametrised decode stage for the 5-stage pipeline.
- Contains the architectural register file, full RV32I/RV64I immediate generation and an ID/EX pipeline register with valid/ready handshake, stall and flush.
- Sits between the IF/ID register and the execute stage; takes writeback from the WB stage.
- Adds over the previous decode block: registered outputs, back-pressure, flush, illegal-opcode flagging and width/depth generality.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- NUM_REGS, 32, register-file depth; power of two, 16 (RV32E) or 32.
- RA_W, $clog2(NUM_REGS), register-address width; derived, not overridden.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- valid_i  in  1  IF/ID holds a valid instruction
- ready_o  out  1  stage can accept the instruction this cycle
- instruction_i  in  32  instruction word
- pc_i  in  XLEN  PC of the instruction
- flush_i  in  1  kill the in-flight and incoming instruction (branch redirect)
- reg_write_i  in  1  WB write enable
- write_addr_reg_i  in  RA_W  WB destination register
- write_data_reg_i  in  XLEN  WB write data
- valid_o  out  1  ID/EX payload valid
- ready_i  in  1  EX accepts the payload
- opcode_o  out  7  instruction[6:0]
- funct3_o  out  3  instruction[14:12]
- funct7_o  out  7  instruction[31:25]
- rs1_o, rs2_o, rd_o  out  RA_W each  register addresses, low RA_W bits of the fields
- read_data1_o, read_data2_o  out  XLEN  operand values
- offset_o  out  XLEN  sign-extended immediate
- pc_o  out  XLEN  registered PC
- illegal_o  out  1  unsupported opcode, or register field ≥ NUM_REGS

Behaviour:
- Reset (asynchronous, rst_ni=0):
  - valid_o=0, illegal_o=0.
  - All payload outputs = 0.
  - All NUM_REGS registers cleared to 0.
  - Reset mid-transfer drops the payload; no partial state survives.
- Handshake:
  - ready_o = !valid_o || ready_i (single-entry pipeline register, no combinational path from valid_i).
  - Capture on the edge where valid_i && ready_o && !flush_i; the payload is visible the next cycle (latency 1).
  - valid_o set on capture; cleared when ready_i && !capture.
  - While valid_o && !ready_i, the payload holds stable, including read_data, even if WB writes that register.
- Flush: flush_i=1 at an edge forces valid_o=0 and suppresses capture the same cycle; payload contents are don't-care. Flush overrides a simultaneous ready_i or valid_i.
- Register file:
  - Write at the clock edge when reg_write_i=1 and write_addr_reg_i≠0.
  - x0 reads 0 always; writes to x0 are ignored.
  - Read is combinational on instruction_i fields and registered at capture.
- Immediates, selected by opcode, always sign-extended from instruction[31] to XLEN:
  - I-type (0000011, 0010011, 1100111, 1110011): inst[31:20].
  - S-type (0100011): {inst[31:25], inst[11:7]}.
  - B-type (1100011): {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
  - U-type (0110111, 0010111): {inst[31:12], 12'b0}; for XLEN=64, bits above 31 are copies of inst[31].
  - J-type (1101111): {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
  - R-type and other opcodes: 0.
- illegal_o: registered with the payload. Set when the opcode is none of the above plus 0110011/0001111, or when NUM_REGS=16 and any used register field has bit 4 set.

Optional Feature:
- Macro: DECODE_WB_BYPASS_EN.
- Defined: at capture, if reg_write_i && write_addr_reg_i==rs1 (or rs2) && address≠0, the captured read_data takes write_data_reg_i (write-through). Bypass also applies on the stall-hold path: a held payload refreshes its operand when WB writes the matching register.
- Undefined: the captured value is the pre-write register contents; the downstream forwarding unit covers the WB→ID hazard. Held payloads are frozen.

Decomposition:
- Package pipeline_pkg holds:
  - opcode localparams (OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OP_IMM, OPC_SYSTEM, OPC_FENCE);
  - an imm_type_e enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE).
- Sub-module decode_imm_gen: combinational, takes the instruction and returns the XLEN immediate plus imm_type.
- The register file stays inline.

Test Plan:
- Reset: rst_ni low mid-transfer with valid_o=1 → valid_o=0 and all outputs 0 immediately; after release, a read of x5 returns 0.
- Immediates: inst 0xFE000EE3 (BEQ, offset -4) → offset_o=0xFFFFFFFC. inst 0x800000EF (JAL) → offset_o=0xFFF00000. LUI 0x12345037 with XLEN=64 → 0x0000000012345000.
- Stall: valid_o=1, ready_i=0 for 3 cycles while valid_i=1 → ready_o=0, payload unchanged. ready_i=1 → next instruction captured the following edge.
- Flush: flush_i=1 on the same edge as valid_i=1 → valid_o=0 next cycle. Flush with valid_o=1, ready_i=0 → valid_o=0.
- Register file: WB writes x0=0xDEADBEEF, then x3=0x1234 → a later read of x0 gives 0 and x3 gives 0x1234. Same-cycle WB x3=0x55 while decoding rs1=3 → read_data1_o=0x55 with DECODE_WB_BYPASS_EN, 0x1234 without.
- Illegal: opcode 0x7F → illegal_o=1. With NUM_REGS=16, rd=17 → illegal_o=1 and rd_o=1.
